// File: rtl/fsm_ring_arbiter.sv
// Token-ring arbiter: one shared resource, 15 requesters visited in ring order.
// A slot is granted when its requester is asking. The grant is released on done,
// when the request is withdrawn, or when the tenure limit is reached. After a
// release the ring always moves to the next slot.
module fsm_ring_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [14:0] req,
  input  logic        done,
  output logic [14:0] grant,
  output logic [3:0]  owner,
  output logic        busy,
  output logic        timeout
);

  localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {SCAN, OWN} phase_t;

  phase_t        phase, phase_nx;
  logic [3:0]    slot, slot_nx, slot_inc;
  logic [CW-1:0] cnt, cnt_nx;
  logic [14:0]   grant_nx;
  logic          busy_nx, timeout_nx, req_cur;

  assign slot_inc = (slot == 4'd14) ? '0 : slot + 4'd1;
  assign req_cur  = req[slot];
  assign owner    = slot;

  // Next-state and registered-output values for the ring FSM
  always_comb begin
    phase_nx   = phase;
    slot_nx    = slot;
    cnt_nx     = cnt;
    grant_nx   = grant;
    timeout_nx = 1'b0;
    unique case (phase)
      SCAN: begin
        grant_nx = '0;
        cnt_nx   = '0;
        if (enable) begin
          if (req_cur) begin
            phase_nx = OWN;
            grant_nx = 15'd1 << slot;
          end else begin
            slot_nx = slot_inc;
          end
        end
      end
      OWN: begin
        cnt_nx = cnt + 1'b1;
        if (done || !req_cur || (cnt == CNT_LAST)) begin
          phase_nx   = SCAN;
          grant_nx   = '0;
          slot_nx    = slot_inc;
          cnt_nx     = '0;
          // done and abandon take priority; only a pure limit hit is a timeout
          timeout_nx = !done && req_cur;
        end
      end
      default: begin
        phase_nx = SCAN;
        grant_nx = '0;
        cnt_nx   = '0;
      end
    endcase
    busy_nx = (phase_nx == OWN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      phase   <= SCAN;
      slot    <= '0;
      cnt     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      phase   <= phase_nx;
      slot    <= slot_nx;
      cnt     <= cnt_nx;
      grant   <= grant_nx;
      busy    <= busy_nx;
      timeout <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_fsm_ring_arbiter.sv
// Scoreboard bench for fsm_ring_arbiter: a driver applies random and directed
// input patterns at the falling edge and pushes the expected registered outputs
// from a behavioural ring model; a monitor pops and compares after each rising edge.
module tb_fsm_ring_arbiter;

  localparam int unsigned HM = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [14:0] req = '0;
  logic        done = 1'b0;
  logic [14:0] grant;
  logic [3:0]  owner;
  logic        busy;
  logic        timeout;

  fsm_ring_arbiter #(.HOLD_MAX(HM)) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [14:0] grant;
    logic [3:0]  owner;
    logic        busy;
    logic        timeout;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model: who holds the resource, where the token is,
  // how many cycles the current tenure has lasted.
  bit m_own = 0;
  int m_pos = 0;
  int m_ten = 0;
  bit m_to  = 0;

  task automatic model_step(input bit r, input bit en, input logic [14:0] rq, input bit dn);
    exp_t e;
    if (r) begin
      m_own = 0; m_pos = 0; m_ten = 0; m_to = 0;
    end else if (m_own) begin
      m_ten = m_ten + 1;
      m_to  = 0;
      if (dn || !rq[m_pos]) begin
        m_own = 0; m_pos = (m_pos + 1) % 15;
      end else if (m_ten == HM) begin
        m_own = 0; m_pos = (m_pos + 1) % 15; m_to = 1;
      end
    end else begin
      m_to = 0;
      if (en) begin
        if (rq[m_pos]) begin
          m_own = 1; m_ten = 0;
        end else begin
          m_pos = (m_pos + 1) % 15;
        end
      end
    end
    e.grant   = m_own ? (15'd1 << m_pos) : 15'd0;
    e.owner   = 4'(m_pos);
    e.busy    = m_own;
    e.timeout = m_to;
    expq.push_back(e);
  endtask

  task automatic drive(input bit r, input bit en, input logic [14:0] rq, input bit dn);
    @(negedge clock);
    reset = r; enable = en; req = rq; done = dn;
    model_step(r, en, rq, dn);
  endtask

  // Monitor: every rising edge the DUT presents a new registered output set
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if (grant !== e.grant || owner !== e.owner || busy !== e.busy || timeout !== e.timeout) begin
          fails++;
          $display("FAIL outputs t=%0t grant=%h/%h owner=%0d/%0d busy=%b/%b timeout=%b/%b (actual/required)",
                   $time, grant, e.grant, owner, e.owner, busy, e.busy, timeout, e.timeout);
        end
      end
    end
  end

  initial begin
    logic [14:0] rq;
    bit dn, en, r;

    // reset
    drive(1, 0, '0, 0);
    drive(1, 0, '0, 0);

    // idle scan, two wraps
    for (int i = 0; i < 32; i++) drive(0, 1, '0, 0);

    // basic grant on slot 0 after reset, done on third tenure cycle
    drive(1, 0, '0, 0);
    drive(0, 1, 15'h0001, 0);
    drive(0, 1, 15'h0001, 0);
    drive(0, 1, 15'h0001, 0);
    drive(0, 1, 15'h0001, 1);
    drive(0, 1, 15'h0000, 0);

    // timeout on slot 5 with request held
    for (int i = 0; i < 60; i++) drive(0, 1, 15'h0020, 0);

    // wrap and fairness: slots 14 and 0, done two cycles into each tenure
    for (int i = 0; i < 120; i++) drive(0, 1, 15'h4001, busy && (i % 3 == 0));

    // done coincident with the limit cycle, then abandon mid-tenure
    drive(1, 0, '0, 0);
    for (int i = 0; i < HM + 1; i++) drive(0, 1, 15'h0001, i == HM);
    for (int i = 0; i < 20; i++) drive(0, 1, 15'h0004, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 15'h0000, 0);

    // reset during a tenure on slot 7
    for (int i = 0; i < 12; i++) drive(0, 1, 15'h0080, 0);
    drive(1, 1, 15'h0080, 0);
    drive(0, 0, 15'h0000, 0);

    // enable low at slot 3 with request pending
    drive(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, '0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 15'h0008, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 15'h0008, i == 3);

    // all requesting, rare done: timeouts and done/limit collisions
    for (int i = 0; i < 400; i++) drive(0, 1, '1, ($urandom_range(0, 19) == 0));

    // sparse random requests each cycle, enable toggling
    for (int i = 0; i < 500; i++) begin
      rq = 15'($urandom) & 15'($urandom) & 15'($urandom);
      dn = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 3) != 0);
      drive(0, en, rq, dn);
    end

    // slowly changing requests, occasional reset
    rq = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, 14)] = ~rq[$urandom_range(0, 14)];
      dn = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 7) != 0);
      r  = ($urandom_range(0, 149) == 0);
      drive(r, en, rq, dn);
    end

    for (int i = 0; i < 3; i++) drive(0, 1, '0, 0);
    @(posedge clock);
    #3;

    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
